// File: rtl/j202_wb_host_bridge.sv
// j202_wb_host_bridge: Wishbone slave bridging Caravel management bus to the J202 host port.
// Ports:
//   wb_clk_i, wb_rst_ni                     clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i  Wishbone slave request
//   wbs_ack_o, wbs_dat_o                    Wishbone single-cycle ack and read data
//   hb_req_o/we_o/be_o/addr_o/wdata_o       host-port request, held until ack or timeout
//   hb_ack_i, hb_rdata_i                    host-port completion and read data
//   core_rst_hold_o                         holds the J202 core in reset (CTRL[0])
//   err_o                                   sticky timeout flag (CTRL[1])
module j202_wb_host_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        hb_req_o,
    output logic        hb_we_o,
    output logic [3:0]  hb_be_o,
    output logic [23:0] hb_addr_o,
    output logic [31:0] hb_wdata_o,
    input  logic        hb_ack_i,
    input  logic [31:0] hb_rdata_i,
    output logic        core_rst_hold_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;
    localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);
    state_t      state, state_n;
    logic [7:0]  timer, to_cnt;
    logic        access, is_csr, hb_done, timeout, ctrl_wr;
    logic [31:0] csr_rdata;
    always_comb begin
        access    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
        is_csr    = wbs_adr_i[23:20] == 4'hF;
        hb_done   = (state == FWD) & hb_req_o & hb_ack_i;
        timeout   = (state == FWD) & hb_req_o & ~hb_ack_i & (timer == TMAX);
        ctrl_wr   = wbs_we_i & wbs_sel_i[0] & (wbs_adr_i[3:2] == 2'd0);
        csr_rdata = (wbs_adr_i[3:2] == 2'd0) ? {30'd0, err_o, core_rst_hold_o} :
                    (wbs_adr_i[3:2] == 2'd1) ? {24'd0, to_cnt} : 32'd0;
        state_n   = state;
        case (state)
            IDLE:    state_n = access ? (is_csr ? RESP : FWD) : IDLE;
            // An aborted master (cyc dropped) gets no ack.
            FWD:     state_n = (hb_done | timeout) ? (wbs_cyc_i ? RESP : IDLE) : FWD;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_n;
    end
    assign wbs_ack_o = state == RESP;
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbs_dat_o       <= '0;
            hb_req_o        <= 1'b0;
            hb_we_o         <= 1'b0;
            hb_be_o         <= '0;
            hb_addr_o       <= '0;
            hb_wdata_o      <= '0;
            core_rst_hold_o <= 1'b1;
            err_o           <= 1'b0;
            to_cnt          <= '0;
            timer           <= '0;
        end else begin
            if (state == IDLE && access && is_csr) begin
                if (!wbs_we_i) begin
                    wbs_dat_o <= csr_rdata;
                end else if (ctrl_wr) begin
                    core_rst_hold_o <= wbs_dat_i[0];
                    // Writing 1 to err clears both the flag and the timeout count.
                    if (wbs_dat_i[1]) begin
                        err_o  <= 1'b0;
                        to_cnt <= '0;
                    end
                end
            end
            if (state == IDLE && access && !is_csr) begin
                hb_req_o   <= 1'b1;
                hb_we_o    <= wbs_we_i;
                hb_be_o    <= wbs_sel_i;
                hb_addr_o  <= wbs_adr_i[23:0];
                hb_wdata_o <= wbs_dat_i;
                timer      <= '0;
            end
            if (state == FWD) begin
                if (hb_done) begin
                    hb_req_o <= 1'b0;
                    if (!hb_we_o) wbs_dat_o <= hb_rdata_i;
                end else if (timeout) begin
                    hb_req_o  <= 1'b0;
                    err_o     <= 1'b1;
                    to_cnt    <= (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;
                    wbs_dat_o <= ERR_DATA;
                end else begin
                    timer <= timer + 8'd1;
                end
            end
        end
    end
endmodule

// File: doc/j202_wb_host_bridge.md
# j202_wb_host_bridge

Wishbone slave sitting between the Caravel management-SoC bus (`wbs_*` at the user-project boundary) and the J202 SoC core's host port. It forwards management reads and writes into the core's 24-bit host address space, with a bounded-wait timeout so a hung core cannot stall the management CPU. It also exposes two local CSRs, one of which holds the J202 core in reset while firmware is loaded.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: bridge window base; the bridge decodes on `wbs_adr_i[31:24]`.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles to wait for `hb_ack_i` (range 1..255).
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on a timeout.

Ports:
- `wb_clk_i`  in  1  clock; the only clock.
- `wb_rst_ni`  in  1  reset; synchronous, active-low.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wbs_we_i`  in  1  Wishbone write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data.
- `hb_req_o`  out  1  host-port request; held until ack or timeout.
- `hb_we_o`  out  1  host-port write.
- `hb_be_o`  out  4  host-port byte enables.
- `hb_addr_o`  out  24  host-port address (`wbs_adr_i[23:0]`).
- `hb_wdata_o`  out  32  host-port write data.
- `hb_ack_i`  in  1  host-port completion.
- `hb_rdata_i`  in  32  host-port read data; valid with `hb_ack_i`.
- `core_rst_hold_o`  out  1  holds the J202 core in reset.
- `err_o`  out  1  sticky timeout flag (mirror of CTRL[1]).

## Operation
- An access is **in-window** when `wbs_cyc_i & wbs_stb_i` and `wbs_adr_i[31:24] == BASE_ADDR[31:24]`.
  - Out-of-window accesses are ignored: no ack, no state change.
- The offset is `wbs_adr_i[23:0]`.
  - If `offset[23:20]==4'hF`: local CSR access.
  - Otherwise: forwarded to the host port.
- CSR map (offset bits [3:2]; other offsets in the CSR region read 0, writes are ignored, and they still ack):
  - 0x00 CTRL.
    - bit0 `core_rst_hold`: RW, resets to 1.
    - bit1 `err`: sticky; write-1-to-clear.
    - Writes honour `wbs_sel_i[0]`.
  - 0x04 STATUS.
    - [7:0] timeout count: RO, saturates at 255.
    - Cleared when a write sets CTRL bit1.
- FSM states: IDLE, FWD, RESP.
  - IDLE → RESP on an in-window CSR access: CSR read/write performed this cycle.
  - IDLE → FWD on an in-window forwarded access.
    - `hb_*` outputs are registered from `wbs_*`.
    - `hb_req_o` goes to 1.
    - Wait timer cleared.
  - FWD, `hb_ack_i`=1:
    - Latch `hb_rdata_i` (reads); drop `hb_req_o`.
    - Go to RESP if `wbs_cyc_i` is still 1, otherwise to IDLE (aborted master: no ack).
  - FWD, no ack, timer == TIMEOUT_CYCLES-1:
    - Drop `hb_req_o`; set `err`; increment the timeout count.
    - Latch `ERR_DATA`; go to RESP (or IDLE if `wbs_cyc_i`=0).
  - FWD, otherwise: timer += 1.
  - RESP: `wbs_ack_o`=1 for exactly one cycle, then IDLE.
- `wbs_cyc_i` falling during FWD does not cancel the host transaction; `hb_req_o` stays high until ack or timeout.
- `hb_ack_i` is ignored whenever `hb_req_o`=0.
- `hb_addr_o`, `hb_we_o`, `hb_be_o` and `hb_wdata_o` are stable for the whole time `hb_req_o`=1.
- The bridge handles one outstanding transaction only; accesses are not accepted outside IDLE.
- A CSR write of `err` clear and a timeout in the same cycle cannot occur (FSM exclusivity).

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `hb_req_o`=0, `hb_we_o`=0, `hb_be_o`=0, `hb_addr_o`=0, `hb_wdata_o`=0.
  - `core_rst_hold_o`=1, `err_o`=0, timeout count 0, FSM in IDLE.
- CSR access: strobe sampled at edge N → `wbs_ack_o` in cycle N+1. Read data is valid with the ack.
- Forwarded access:
  - Strobe sampled at N → `hb_req_o` high from N+1.
  - `hb_ack_i` sampled at M → `hb_req_o` low at M+1 and `wbs_ack_o`/`wbs_dat_o` valid at M+1.
  - Minimum latency is 2 cycles, with zero-wait `hb_ack_i` at N+1.
- Timeout: with no ack, `hb_req_o` is high for exactly TIMEOUT_CYCLES cycles. `wbs_ack_o` follows in the next cycle.
- In IDLE, `wbs_dat_o` holds its last value.
- The cycle after RESP is IDLE, and a new strobe is accepted there.
- Reset mid-FWD: `hb_req_o` drops on the reset edge and the transaction is abandoned.

## Test plan
- Reset, then read 0x30F0_0000 → ack after 1 cycle, data 0x1, `core_rst_hold_o`=1. Write 0x0 with sel=4'h1 → `core_rst_hold_o`=0.
- Write 0x3000_1234 data 0xCAFEF00D sel=4'hF, core acks after 3 cycles → `hb_addr_o`=24'h001234, `hb_wdata_o`=0xCAFEF00D, `hb_be_o`=4'hF held 3 cycles; one `wbs_ack_o` pulse.
- Read 0x3000_0040, core returns 0x12345678 with zero wait → `wbs_ack_o` 2 cycles after the strobe, `wbs_dat_o`=0x12345678.
- Read with the core never acking, TIMEOUT_CYCLES=16 → `hb_req_o` high 16 cycles, then ack with 0xDEADBEEF, `err_o`=1, STATUS=1. Write CTRL=0x2 → `err_o`=0, STATUS=0.
- Access 0x2000_0000 → no ack and `hb_req_o` stays 0. Master drops `wbs_cyc_i` mid-FWD → `hb_req_o` held until `hb_ack_i`, no `wbs_ack_o`.
- Assert `wb_rst_ni`=0 during FWD → next cycle `hb_req_o`=0 and all outputs at their reset values.
